// File: rtl/gemini_pipe_pkg.sv
// Shared constants for the pipeline hazard/redirect controller.
// Stage and boundary-register indices, redirect FSM encoding.
package gemini_pipe_pkg;

    localparam int N_REG = 5;

    localparam int STG_IF  = 0;
    localparam int STG_ID1 = 1;
    localparam int STG_ID2 = 2;
    localparam int STG_EX  = 3;
    localparam int STG_MEM = 4;

    localparam int R_IF_ID1  = 0;
    localparam int R_ID1_ID2 = 1;
    localparam int R_ID2_EX  = 2;
    localparam int R_EX_MEM  = 3;
    localparam int R_MEM_WB  = 4;

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_BR_PEND  = 2'd1,
        RD_EXC_PEND = 2'd2
    } rd_state_e;

    // Hold mask for every boundary register in front of stage k
    function automatic logic [N_REG-1:0] hold_below(int k);
        hold_below = '0;
        for (int i = 0; i < N_REG; i++) begin
            if (i < k) hold_below[i] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/pipe_redirect.sv
// Front-end redirect FSM: latches branch/exception targets
// and holds the request until IF accepts it.
module pipe_redirect
    import gemini_pipe_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        exc_valid,
    input  logic [31:0] exc_target,
    input  logic        redirect_ready,
    output logic        br_take,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    rd_state_e state;

    // A pending exception redirect swallows any branch request
    assign br_take = br_req && (state != RD_EXC_PEND);

    // Exceptions preempt everything; branches only start from idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= RD_IDLE;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else if (exc_valid) begin
            state          <= RD_EXC_PEND;
            redirect_valid <= 1'b1;
            redirect_pc    <= exc_target;
        end else begin
            unique case (state)
                RD_IDLE: begin
                    if (br_take) begin
                        state          <= RD_BR_PEND;
                        redirect_valid <= 1'b1;
                        redirect_pc    <= br_target;
                    end
                end
                RD_BR_PEND, RD_EXC_PEND: begin
                    if (redirect_ready) begin
                        state          <= RD_IDLE;
                        redirect_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= RD_IDLE;
                    redirect_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and redirect controller: stall/flush
// encoding, branch kill tracking and stall-cycle counter.
module pipe_ctrl
    import gemini_pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_miss,
    input  logic             load_use,
    input  logic             div_busy,
    input  logic             d_miss,
    input  logic             br_flush,
    input  logic [31:0]      br_target,
    input  logic             exc_valid,
    input  logic [31:0]      exc_target,
    input  logic             redirect_ready,
    output logic             pc_stall,
    output logic [4:0]       stall,
    output logic [4:0]       flush,
    output logic             exception_flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             any_src;
    logic             ex_adv;
    logic             br_take;
    logic             kill_r0_pend;
    logic [N_REG-1:0] src_stall;
    logic [N_REG-1:0] src_flush;

    assign any_src = i_miss | load_use | div_busy | d_miss;
    assign ex_adv  = !(div_busy | d_miss);

    // Deepest active source holds everything in front and bubbles itself
    always_comb begin
        src_stall = '0;
        src_flush = '0;
        if (d_miss) begin
            src_stall = hold_below(STG_MEM);
            src_flush[R_MEM_WB] = 1'b1;
        end else if (div_busy) begin
            src_stall = hold_below(STG_EX);
            src_flush[R_EX_MEM] = 1'b1;
        end else if (load_use) begin
            src_stall = hold_below(STG_ID2);
            src_flush[R_ID2_EX] = 1'b1;
        end else if (i_miss) begin
            src_flush[R_IF_ID1] = 1'b1;
        end
    end

    // Wrong-path kill of ID1, also replayed while a stall masks it
    always_comb begin
        flush = src_flush;
        flush[R_IF_ID1] = src_flush[R_IF_ID1] | br_take | kill_r0_pend;
    end

    assign stall           = src_stall;
    assign pc_stall        = any_src;
    assign exception_flush = exc_valid;

    // Remember a branch kill that landed while r0 was held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill_r0_pend <= 1'b0;
        end else if (exc_valid) begin
            kill_r0_pend <= 1'b0;
        end else if (br_take && src_stall[R_IF_ID1]) begin
            kill_r0_pend <= 1'b1;
        end else if (!src_stall[R_IF_ID1]) begin
            kill_r0_pend <= 1'b0;
        end
    end

    // Saturating count of cycles with any stall source active
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= '0;
        end else if (any_src && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

    pipe_redirect u_redirect (
        .clk            (clk),
        .rst            (rst),
        .br_req         (br_flush & ex_adv),
        .br_target      (br_target),
        .exc_valid      (exc_valid),
        .exc_target     (exc_target),
        .redirect_ready (redirect_ready),
        .br_take        (br_take),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus
// randomized traffic against a behavioural reference model.
module tb_pipe_ctrl;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_miss, load_use, div_busy, d_miss;
    logic          br_flush, exc_valid, redirect_ready;
    logic [31:0]   br_target, exc_target;
    logic          pc_stall, exception_flush, redirect_valid;
    logic [4:0]    stall, flush;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] stall_cycles;

    int vec = 0;
    int bad = 0;

    bit          m_vld, m_exc, m_pend;
    logic [31:0] m_pc;
    int          m_cnt;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .load_use(load_use),
        .div_busy(div_busy), .d_miss(d_miss),
        .br_flush(br_flush), .br_target(br_target),
        .exc_valid(exc_valid), .exc_target(exc_target),
        .redirect_ready(redirect_ready),
        .pc_stall(pc_stall), .stall(stall), .flush(flush),
        .exception_flush(exception_flush),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .stall_cycles(stall_cycles)
    );

    function automatic int deepest();
        if (d_miss) return 4;
        if (div_busy) return 3;
        if (load_use) return 2;
        if (i_miss) return 0;
        return -1;
    endfunction

    function automatic logic [4:0] e_stall();
        int k = deepest();
        return (k > 0) ? 5'((1 << k) - 1) : 5'd0;
    endfunction

    function automatic bit e_take();
        return br_flush && !div_busy && !d_miss && !(m_vld && m_exc);
    endfunction

    function automatic logic [4:0] e_flush();
        int k = deepest();
        logic [4:0] f = (k >= 0) ? 5'(1 << k) : 5'd0;
        if (e_take() || m_pend) f[0] = 1'b1;
        return f;
    endfunction

    function automatic void model_reset();
        m_vld = 0; m_exc = 0; m_pend = 0;
        m_pc = '0; m_cnt = 0;
    endfunction

    function automatic void model_tick();
        logic [4:0] s = e_stall();
        bit tk = e_take();
        if (exc_valid) begin
            m_vld = 1; m_exc = 1; m_pc = exc_target;
        end else if (!m_vld && tk) begin
            m_vld = 1; m_exc = 0; m_pc = br_target;
        end else if (m_vld && redirect_ready) begin
            m_vld = 0;
        end
        if (exc_valid) m_pend = 0;
        else if (tk && s[0]) m_pend = 1;
        else if (!s[0]) m_pend = 0;
        if ((i_miss | load_use | div_busy | d_miss) && m_cnt < CMAX)
            m_cnt++;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic clear_inputs();
        i_miss = 0; load_use = 0; div_busy = 0; d_miss = 0;
        br_flush = 0; exc_valid = 0; redirect_ready = 0;
        br_target = '0; exc_target = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1; #1; rst = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        vec++;
        if ({pc_stall, stall, flush, exception_flush, redirect_valid,
             redirect_pc, stall_cycles} !== '0) begin
            bad++;
            $display("FAIL reset: got %b %b %b %b %b %h %h want all zero",
                     pc_stall, stall, flush, exception_flush,
                     redirect_valid, redirect_pc, stall_cycles);
        end
        @(posedge clk); #1;
        rst = 1;
    endtask

    task automatic test_priority();
        d_miss = 1; load_use = 1;
        @(negedge clk);
        vec++;
        if ({pc_stall, stall, flush} !== {1'b1, 5'b01111, 5'b10000}) begin
            bad++;
            $display("FAIL prio_dmiss: got %b want %b",
                     {pc_stall, stall, flush}, {1'b1, 5'b01111, 5'b10000});
        end
        tick();
        d_miss = 0;
        @(negedge clk);
        vec++;
        if ({pc_stall, stall, flush} !== {1'b1, 5'b00011, 5'b00100}) begin
            bad++;
            $display("FAIL prio_lu: got %b want %b",
                     {pc_stall, stall, flush}, {1'b1, 5'b00011, 5'b00100});
        end
        tick();
        load_use = 0;
        @(negedge clk);
        vec++;
        if ({pc_stall, stall, flush} !== '0) begin
            bad++;
            $display("FAIL prio_none: got %b want 0", {pc_stall, stall, flush});
        end
        tick();
    endtask

    task automatic test_branch();
        br_flush = 1; br_target = 32'hBFC00380;
        @(negedge clk);
        vec++;
        if (flush !== 5'b00001 || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL br_kill: got flush %b rv %b want 00001 0",
                     flush, redirect_valid);
        end
        tick();
        br_flush = 0; redirect_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC00380) begin
                bad++;
                $display("FAIL br_hold%0d: got %b %h want 1 bfc00380",
                         i, redirect_valid, redirect_pc);
            end
            tick();
        end
        redirect_ready = 1;
        @(negedge clk);
        vec++;
        if (redirect_valid !== 1'b1) begin
            bad++;
            $display("FAIL br_ready: got %b want 1", redirect_valid);
        end
        tick();
        redirect_ready = 0;
        @(negedge clk);
        vec++;
        if (redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL br_clear: got %b want 0", redirect_valid);
        end
        tick();
    endtask

    task automatic test_branch_load_use();
        br_flush = 1; load_use = 1; br_target = 32'h0000_1000;
        @(negedge clk);
        vec++;
        if (stall !== 5'b00011 || flush !== 5'b00101) begin
            bad++;
            $display("FAIL brlu_0: got %b %b want 00011 00101", stall, flush);
        end
        tick();
        br_flush = 0; redirect_ready = 1;
        @(negedge clk);
        vec++;
        if (flush !== 5'b00101 || redirect_valid !== 1'b1) begin
            bad++;
            $display("FAIL brlu_hold: got %b %b want 00101 1",
                     flush, redirect_valid);
        end
        tick();
        load_use = 0; redirect_ready = 0;
        @(negedge clk);
        vec++;
        if (stall !== 5'b00000 || flush !== 5'b00001) begin
            bad++;
            $display("FAIL brlu_kill: got %b %b want 00000 00001", stall, flush);
        end
        tick();
        @(negedge clk);
        vec++;
        if (flush !== 5'b00000 || redirect_valid !== 1'b0) begin
            bad++;
            $display("FAIL brlu_done: got %b %b want 00000 0",
                     flush, redirect_valid);
        end
        tick();
    endtask

    task automatic test_branch_div();
        br_flush = 1; div_busy = 1; br_target = 32'h0000_2000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vec++;
            if (flush !== 5'b01000 || redirect_valid !== 1'b0) begin
                bad++;
                $display("FAIL brdiv%0d: got %b %b want 01000 0",
                         i, flush, redirect_valid);
            end
            tick();
        end
        div_busy = 0;
        @(negedge clk);
        vec++;
        if (flush !== 5'b00001) begin
            bad++;
            $display("FAIL brdiv_acc: got %b want 00001", flush);
        end
        tick();
        br_flush = 0;
        @(negedge clk);
        vec++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_2000) begin
            bad++;
            $display("FAIL brdiv_rd: got %b %h want 1 00002000",
                     redirect_valid, redirect_pc);
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
    endtask

    task automatic test_exception();
        br_flush = 1; br_target = 32'h8000_1000;
        tick();
        br_flush = 0;
        exc_valid = 1; exc_target = 32'h8000_0180;
        @(negedge clk);
        vec++;
        if (exception_flush !== 1'b1 || redirect_pc !== 32'h8000_1000) begin
            bad++;
            $display("FAIL exc_pulse: got %b %h want 1 80001000",
                     exception_flush, redirect_pc);
        end
        tick();
        exc_valid = 0;
        @(negedge clk);
        vec++;
        if (exception_flush !== 1'b0 || redirect_valid !== 1'b1 ||
            redirect_pc !== 32'h8000_0180) begin
            bad++;
            $display("FAIL exc_over: got %b %b %h want 0 1 80000180",
                     exception_flush, redirect_valid, redirect_pc);
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        br_flush = 1; br_target = 32'h3000;
        exc_valid = 1; exc_target = 32'h4000;
        tick();
        exc_valid = 0; br_target = 32'h5000;
        @(negedge clk);
        vec++;
        if (redirect_pc !== 32'h4000 || flush !== 5'b00000) begin
            bad++;
            $display("FAIL exc_same: got %h %b want 00004000 00000",
                     redirect_pc, flush);
        end
        tick();
        br_flush = 0;
        @(negedge clk);
        vec++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h4000) begin
            bad++;
            $display("FAIL exc_ign: got %b %h want 1 00004000",
                     redirect_valid, redirect_pc);
        end
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            i_miss         = ($urandom % 4) == 0;
            load_use       = ($urandom % 5) == 0;
            div_busy       = ($urandom % 6) == 0;
            d_miss         = ($urandom % 8) == 0;
            br_flush       = ($urandom % 3) == 0;
            exc_valid      = ($urandom % 16) == 0;
            redirect_ready = ($urandom % 2) == 0;
            br_target      = $urandom;
            exc_target     = $urandom;
            @(negedge clk);
            vec++;
            if ({pc_stall, stall, flush, exception_flush} !==
                {deepest() >= 0, e_stall(), e_flush(), exc_valid}) begin
                bad++;
                $display("FAIL rnd_comb%0d: got %b want %b", n,
                         {pc_stall, stall, flush, exception_flush},
                         {deepest() >= 0, e_stall(), e_flush(), exc_valid});
            end
            vec++;
            if ({redirect_valid, redirect_pc, stall_cycles} !==
                {m_vld, m_pc, CW'(m_cnt)}) begin
                bad++;
                $display("FAIL rnd_reg%0d: got %b %h %0d want %b %h %0d", n,
                         redirect_valid, redirect_pc, stall_cycles,
                         m_vld, m_pc, m_cnt);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_counter_sat();
        rst = 0; #1; rst = 1;
        model_reset();
        i_miss = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            vec++;
            if (stall_cycles !== CW'((i > CMAX) ? CMAX : i)) begin
                bad++;
                $display("FAIL cnt%0d: got %0d want %0d", i,
                         stall_cycles, (i > CMAX) ? CMAX : i);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        br_flush = 1; br_target = 32'h6000;
        tick();
        br_flush = 0;
        @(negedge clk);
        vec++;
        if (redirect_valid !== 1'b1 || stall_cycles === '0) begin
            bad++;
            $display("FAIL arst_pre: got %b %0d want 1 nonzero",
                     redirect_valid, stall_cycles);
        end
        #2 rst = 0;
        #1;
        vec++;
        if ({redirect_valid, redirect_pc, stall_cycles} !== '0) begin
            bad++;
            $display("FAIL arst_now: got %b %h %0d want 0 0 0",
                     redirect_valid, redirect_pc, stall_cycles);
        end
        @(posedge clk);
        model_reset();
        #1;
        rst = 1; i_miss = 0;
        @(negedge clk);
        vec++;
        if ({redirect_valid, stall_cycles, flush} !== '0) begin
            bad++;
            $display("FAIL arst_post: got %b %0d %b want 0 0 0",
                     redirect_valid, stall_cycles, flush);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_priority();
        test_branch();
        test_branch_load_use();
        test_branch_div();
        test_exception();
        test_random();
        test_counter_sat();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
